// File: rtl/acu_pkg.sv
// Shared types and encodings for the accumulator CPU sequencer.
// The INDIRECT state exists only when ACU_INDIRECT_EN is defined.
package acu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
`ifdef ACU_INDIRECT_EN
        ST_INDIRECT = 3'd3,
`endif
        ST_EXEC     = 3'd4,
        ST_HALT     = 3'd5
    } acu_state_e;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_BUN = 3'b100;
    localparam logic [2:0] OP_BZ  = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SYS = 3'b111;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int IND_BIT = 4;
    localparam int ADR_MSB = 3;
    localparam int ADR_LSB = 0;

    localparam logic [7:0] HLT_ENC = 8'hE0;

    // Opcodes whose EXEC cycle needs the memory operand
    function automatic logic op_reads(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_LDA) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/accumulator_control_unit_if.sv
// Memory-side bus of the sequencer: the CPU is master, the unified memory is slave.
interface accumulator_control_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_rd, output mem_wr, output mem_wdata,
                    input  mem_rdata);
    modport slave  (input  mem_addr, input  mem_rd, input  mem_wr, input  mem_wdata,
                    output mem_rdata);
endinterface

// File: rtl/acu_alu.sv
// Combinational accumulator datapath: next AC and carry for the EXEC cycle.
module acu_alu
    import acu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] ac_i,
    input  logic [DATA_W-1:0] m_i,
    input  logic [2:0]        op_i,
    output logic [DATA_W-1:0] ac_o,
    output logic              carry_o,
    output logic              carry_we_o
);

    always_comb begin
        ac_o       = ac_i;
        carry_o    = 1'b0;
        carry_we_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                {carry_o, ac_o} = {1'b0, ac_i} + {1'b0, m_i};
                carry_we_o      = 1'b1;
            end
            OP_AND: ac_o = ac_i & m_i;
            OP_LDA: ac_o = m_i;
            OP_SUB: begin
                ac_o       = ac_i - m_i;
                carry_o    = (ac_i < m_i);
                carry_we_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/accumulator_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Define ACU_INDIRECT_EN to build the INDIRECT state and honour IR[4].
module accumulator_control_unit
    import acu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    accumulator_control_unit_if.master  mem,
    output logic [ADDR_W-1:0]           pc,
    output logic [DATA_W-1:0]           ac,
    output logic                        carry,
    output logic                        halted
);

    acu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ar_q, ar_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic              carry_q, carry_d;
    // IR is held as its decoded fields
    logic [2:0]        ir_op_q, ir_op_d;
    logic [ADDR_W-1:0] ir_adr_q, ir_adr_d;
`ifdef ACU_INDIRECT_EN
    logic              ir_ind_q, ir_ind_d;
`endif

    logic [DATA_W-1:0] alu_ac;
    logic              alu_carry;
    logic              alu_carry_we;
    logic              is_hlt;

    acu_alu #(.DATA_W(DATA_W)) u_alu (
        .ac_i       (ac_q),
        .m_i        (mem.mem_rdata),
        .op_i       (ir_op_q),
        .ac_o       (alu_ac),
        .carry_o    (alu_carry),
        .carry_we_o (alu_carry_we)
    );

`ifdef ACU_INDIRECT_EN
    assign is_hlt = (ir_op_q == OP_SYS) && !ir_ind_q && (ir_adr_q == '0);
`else
    assign is_hlt = (ir_op_q == OP_SYS) && (ir_adr_q == '0);
`endif

    assign pc     = pc_q;
    assign ac     = ac_q;
    assign carry  = carry_q;
    assign halted = (state_q == ST_HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ar_q     <= '0;
            ac_q     <= '0;
            carry_q  <= 1'b0;
            ir_op_q  <= '0;
            ir_adr_q <= '0;
`ifdef ACU_INDIRECT_EN
            ir_ind_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ar_q     <= ar_d;
            ac_q     <= ac_d;
            carry_q  <= carry_d;
            ir_op_q  <= ir_op_d;
            ir_adr_q <= ir_adr_d;
`ifdef ACU_INDIRECT_EN
            ir_ind_q <= ir_ind_d;
`endif
        end
    end

    // Bus idles on PC/AC so the memory sees a stable address whenever nothing is accessed
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ar_d          = ar_q;
        ac_d          = ac_q;
        carry_d       = carry_q;
        ir_op_d       = ir_op_q;
        ir_adr_d      = ir_adr_q;
`ifdef ACU_INDIRECT_EN
        ir_ind_d      = ir_ind_q;
`endif
        mem.mem_addr  = pc_q;
        mem.mem_rd    = 1'b0;
        mem.mem_wr    = 1'b0;
        mem.mem_wdata = ac_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem.mem_rd = 1'b1;
                ir_op_d    = mem.mem_rdata[OP_MSB:OP_LSB];
                ir_adr_d   = mem.mem_rdata[ADDR_W-1:0];
`ifdef ACU_INDIRECT_EN
                ir_ind_d   = mem.mem_rdata[IND_BIT];
`endif
                pc_d       = pc_q + 1'b1;
                state_d    = ST_DECODE;
            end
            ST_DECODE: begin
                ar_d = ir_adr_q;
                if (ir_op_q == OP_SYS)
                    state_d = is_hlt ? ST_HALT : ST_FETCH;
`ifdef ACU_INDIRECT_EN
                else if (ir_ind_q)
                    state_d = ST_INDIRECT;
`endif
                else
                    state_d = ST_EXEC;
            end
`ifdef ACU_INDIRECT_EN
            ST_INDIRECT: begin
                mem.mem_addr = ar_q;
                mem.mem_rd   = 1'b1;
                ar_d         = mem.mem_rdata[ADDR_W-1:0];
                state_d      = ST_EXEC;
            end
`endif
            ST_EXEC: begin
                if (op_reads(ir_op_q)) begin
                    mem.mem_addr = ar_q;
                    mem.mem_rd   = 1'b1;
                end
                if (ir_op_q == OP_STA) begin
                    mem.mem_addr = ar_q;
                    mem.mem_wr   = 1'b1;
                end
                ac_d = alu_ac;
                if (alu_carry_we) carry_d = alu_carry;
                if ((ir_op_q == OP_BUN) || ((ir_op_q == OP_BZ) && (ac_q == '0)))
                    pc_d = ar_q;
                state_d = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Directed self-checking bench for accumulator_control_unit with a 16x8 memory model.
module tb_accumulator_control_unit;
    import acu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] pc;
    logic [7:0] ac;
    logic       carry;
    logic       halted;

    always #5 clk = ~clk;

    accumulator_control_unit_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    accumulator_control_unit #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mem    (bus.master),
        .pc     (pc),
        .ac     (ac),
        .carry  (carry),
        .halted (halted)
    );

    logic [7:0] mem [16];
    logic [7:0] img [16];
    logic       load_en = 1'b0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (load_en) mem <= img;
        else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int bad_cnt = 0;
    logic mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_wr) wr_cnt++;
            if (bus.mem_rd && bus.mem_wr) bad_cnt++;
            if (!bus.mem_rd && !bus.mem_wr && (bus.mem_addr !== pc || bus.mem_wdata !== ac)) bad_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
    endtask

    task automatic load_and_reset();
        rst_n = 1'b0;
        load_en = 1'b1;
        step(1);
        load_en = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic kick();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        n_vec++; if (pc !== 4'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc); end
        n_vec++; if (ac !== 8'h00) begin n_err++; $display("FAIL reset_ac: got %h want 00", ac); end
        n_vec++; if (carry !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL reset_flags: carry %b halted %b want 0 0", carry, halted); end
        n_vec++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0 || bus.mem_addr !== 4'h0 || bus.mem_wdata !== 8'h00) begin
            n_err++; $display("FAIL reset_bus: rd %b wr %b addr %h wdata %h want 0 0 0 00", bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata); end
        n_vec++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        rst_n = 1'b1;
        step(3);
        n_vec++; if (dut.state_q !== ST_IDLE || bus.mem_rd !== 1'b0 || pc !== 4'h0) begin
            n_err++; $display("FAIL idle_hold: state %0d rd %b pc %h want IDLE 0 0", dut.state_q, bus.mem_rd, pc); end
        mon_en = 1'b1;
    endtask

    task automatic test_program();
        logic [7:0] hlt;
        hlt = HLT_ENC;
        clear_img();
        img[0] = 8'h49; img[1] = 8'h0A; img[2] = hlt; img[9] = 8'h08; img[10] = 8'h02;
        load_and_reset();
        kick();
        step(7);
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL prog_early_halt: got %b want 0", halted); end
        step(1);
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL prog_halted: got %b want 1", halted); end
        n_vec++; if (ac !== 8'h0A) begin n_err++; $display("FAIL prog_ac: got %h want 0a", ac); end
        n_vec++; if (pc !== 4'h3) begin n_err++; $display("FAIL prog_pc: got %h want 3", pc); end
        start = 1'b1;
        step(2);
        start = 1'b0;
        n_vec++; if (halted !== 1'b1 || pc !== 4'h3 || bus.mem_rd !== 1'b0) begin
            n_err++; $display("FAIL halt_absorb: halted %b pc %h rd %b want 1 3 0", halted, pc, bus.mem_rd); end
    endtask

    task automatic test_indirect();
        clear_img();
        img[0] = 8'h5C; img[1] = 8'hE0; img[12] = 8'h09; img[9] = 8'h08;
        load_and_reset();
        kick();
        step(3);
`ifdef ACU_INDIRECT_EN
        n_vec++; if (ac !== 8'h00) begin n_err++; $display("FAIL ind_early: ac %h want 00", ac); end
        step(1);
        n_vec++; if (ac !== 8'h08) begin n_err++; $display("FAIL ind_ac: got %h want 08", ac); end
        n_vec++; if (dut.ar_q !== 4'h9) begin n_err++; $display("FAIL ind_ar: got %h want 9", dut.ar_q); end
`else
        n_vec++; if (ac !== 8'h09) begin n_err++; $display("FAIL dir_ac: got %h want 09", ac); end
        n_vec++; if (dut.ar_q !== 4'hC) begin n_err++; $display("FAIL dir_ar: got %h want c", dut.ar_q); end
`endif
    endtask

    task automatic test_carry();
        clear_img();
        img[0] = 8'h4A; img[10] = 8'hFF; img[1] = 8'h0B; img[11] = 8'h01;
        img[2] = 8'hA7; img[7] = 8'hCB; img[8] = 8'h2B; img[9] = 8'hE0;
        load_and_reset();
        kick();
        step(3);
        n_vec++; if (ac !== 8'hFF || carry !== 1'b0) begin n_err++; $display("FAIL lda_ff: ac %h c %b want ff 0", ac, carry); end
        step(3);
        n_vec++; if (ac !== 8'h00 || carry !== 1'b1) begin n_err++; $display("FAIL add_wrap: ac %h c %b want 00 1", ac, carry); end
        step(3);
        n_vec++; if (pc !== 4'h7) begin n_err++; $display("FAIL bz_taken: pc %h want 7", pc); end
        step(3);
        n_vec++; if (ac !== 8'hFF || carry !== 1'b1 || pc !== 4'h8) begin
            n_err++; $display("FAIL sub_borrow: ac %h c %b pc %h want ff 1 8", ac, carry, pc); end
        step(3);
        n_vec++; if (ac !== 8'h01 || carry !== 1'b1) begin n_err++; $display("FAIL and_hold_c: ac %h c %b want 01 1", ac, carry); end
        step(2);
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL carry_halt: got %b want 1", halted); end
    endtask

    task automatic test_sta();
        int base;
        clear_img();
        img[0] = 8'h4A; img[10] = 8'h0A; img[1] = 8'h6F; img[2] = 8'hE0;
        load_and_reset();
        kick();
        base = wr_cnt;
        step(3);
        n_vec++; if (ac !== 8'h0A) begin n_err++; $display("FAIL sta_pre_ac: got %h want 0a", ac); end
        step(2);
        n_vec++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 4'hF || bus.mem_wdata !== 8'h0A) begin
            n_err++; $display("FAIL sta_bus: wr %b rd %b addr %h wdata %h want 1 0 f 0a", bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata); end
        step(3);
        n_vec++; if (wr_cnt - base !== 1) begin n_err++; $display("FAIL sta_wr_count: got %0d want 1", wr_cnt - base); end
        n_vec++; if (mem[15] !== 8'h0A) begin n_err++; $display("FAIL sta_mem: got %h want 0a", mem[15]); end
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL sta_halt: got %b want 1", halted); end
    endtask

    task automatic test_bun_wrap();
        clear_img();
        img[0] = 8'h8F;
`ifdef ACU_INDIRECT_EN
        img[15] = 8'hF0;
`else
        img[15] = 8'hE1;
`endif
        load_and_reset();
        kick();
        step(3);
        n_vec++; if (pc !== 4'hF) begin n_err++; $display("FAIL bun_pc: got %h want f", pc); end
        step(1);
        n_vec++; if (pc !== 4'h0) begin n_err++; $display("FAIL pc_wrap: got %h want 0", pc); end
        step(1);
        n_vec++; if (bus.mem_addr !== 4'h0 || bus.mem_rd !== 1'b1 || halted !== 1'b0) begin
            n_err++; $display("FAIL nop_refetch: addr %h rd %b halted %b want 0 1 0", bus.mem_addr, bus.mem_rd, halted); end
    endtask

    task automatic test_reset_mid_exec();
        clear_img();
        img[0] = 8'h4A; img[10] = 8'h37; img[1] = 8'h84; img[4] = 8'h0B; img[11] = 8'h01;
        load_and_reset();
        kick();
        step(8);
        n_vec++; if (ac !== 8'h37 || pc !== 4'h5 || bus.mem_rd !== 1'b1) begin
            n_err++; $display("FAIL mid_setup: ac %h pc %h rd %b want 37 5 1", ac, pc, bus.mem_rd); end
        rst_n = 1'b0;
        step(1);
        n_vec++; if (pc !== 4'h0 || ac !== 8'h00 || carry !== 1'b0 || halted !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_regs: pc %h ac %h c %b h %b want 0 00 0 0", pc, ac, carry, halted); end
        n_vec++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0 || dut.state_q !== ST_IDLE) begin
            n_err++; $display("FAIL mid_reset_bus: rd %b wr %b state %0d want 0 0 IDLE", bus.mem_rd, bus.mem_wr, dut.state_q); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_program();
        test_indirect();
        test_carry();
        test_sta();
        test_bun_wrap();
        test_reset_mid_exec();
        n_vec++; if (bad_cnt !== 0) begin n_err++; $display("FAIL bus_invariant: %0d bad cycles want 0", bad_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/accumulator_control_unit.md
# accumulator_control_unit

Fetch/decode/execute sequencer for the 8-bit accumulator CPU. It sits directly upstream of the 16×8 unified memory and drives its `address`, `read`, `write` and `data_in`. It consumes `data_out` as instruction or operand and holds the architectural state: PC, IR, AR, AC and carry. One instruction completes every 3 cycles, or 4 cycles when the instruction is indirect.

## Interface
- `ADDR_W`, default 4: memory address width; PC and AR width.
- `DATA_W`, default 8: data, AC and IR width; opcode field fixed at `IR[7:5]`, indirect bit `IR[4]`, address `IR[3:0]`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `start` in 1: leave IDLE and begin fetching at PC.
- `mem_addr` out ADDR_W: to memory `address`.
- `mem_rd` out 1: to memory `read`.
- `mem_wr` out 1: to memory `write`.
- `mem_wdata` out DATA_W: to memory `data_in`.
- `mem_rdata` in DATA_W: from memory `data_out`; combinational, valid in the same cycle as `mem_rd`.
- `pc` out ADDR_W: program counter.
- `ac` out DATA_W: accumulator.
- `carry` out 1: carry (ADD) or borrow (SUB) flag.
- `halted` out 1: high while in HALT.

## Operation
- States: IDLE, FETCH, DECODE, INDIRECT, EXEC, HALT.
- IDLE: memory idle. `start`=1 moves to FETCH.
- FETCH: `mem_addr`=PC, `mem_rd`=1. IR<=`mem_rdata`. PC<=PC+1, modulo 16, so 15 wraps to 0. Moves to DECODE.
- DECODE: AR<=IR[3:0].
  - Opcode 111 with IR[4:0]=0 (HLT): move to HALT.
  - Opcode 111 with any other IR[4:0] (NOP): move to FETCH.
  - IR[4]=1 on any other opcode: move to INDIRECT.
  - Otherwise: move to EXEC.
- INDIRECT: `mem_addr`=AR, `mem_rd`=1. AR<=`mem_rdata[3:0]`; upper bits are ignored. Moves to EXEC.
- EXEC: `mem_addr`=AR. Operand M = `mem_rdata`; `mem_rd`=1 for ADD, AND, LDA and SUB only. Opcodes:
  - 000 ADD: {carry,AC}<=AC+M, 9-bit.
  - 001 AND: AC<=AC&M.
  - 010 LDA: AC<=M.
  - 011 STA: `mem_wr`=1, `mem_wdata`=AC.
  - 100 BUN: PC<=AR.
  - 101 BZ: PC<=AR if AC==0.
  - 110 SUB: AC<=AC−M modulo 256; carry<=1 on borrow (AC<M).
  - Always moves to FETCH.
- Carry is written only by ADD and SUB. All other opcodes hold it.
- HALT: absorbing. Only `rst_n`=0 leaves it. `start` is ignored.
- `mem_rd` and `mem_wr` are never high in the same cycle. `mem_wr` is high for exactly one cycle per STA, with `mem_addr` and `mem_wdata` stable for that cycle.
- In every cycle where `mem_rd`=0 and `mem_wr`=0, `mem_addr`=PC and `mem_wdata`=AC.

## Timing
- Reset, taking effect at the first clock edge with `rst_n`=0, including mid-instruction:
  - State=IDLE; PC=0, IR=0, AR=0, AC=0x00, carry=0.
  - `mem_rd`=0, `mem_wr`=0, `halted`=0, `mem_addr`=0, `mem_wdata`=0x00.
  - An STA in EXEC during the reset cycle still drives `mem_wr` combinationally for that cycle. The memory sees it.
- Memory read latency is 0 cycles: data is sampled at the edge ending the `mem_rd` cycle.
- Cycles per instruction, counted FETCH-inclusive:
  - Direct: 3.
  - Indirect: 4.
  - NOP: 2.
  - HLT: 2, then `halted`=1 from the third cycle.
- Results appear on `ac`, `pc` and `carry` one edge after EXEC (or after FETCH for the PC increment).
- The IDLE→FETCH transition costs one cycle after `start` is sampled high.

## Configuration
- `ACU_INDIRECT_EN` defined: INDIRECT state present; IR[4] selects indirect addressing as above.
- Not defined:
  - INDIRECT state is not synthesized.
  - IR[4] is ignored for opcodes 000–110, so every such instruction is direct and takes 3 cycles.
  - Opcode 111 decodes on IR[3:0] only: 0 is HLT, anything else is NOP.

## Structure
- Shared package `acu_pkg`:
  - state enum.
  - opcode localparams (`OP_ADD` … `OP_SYS`).
  - IR field positions.
  - HLT encoding 0xE0.
- One sub-module, `acu_alu`: combinational; inputs AC, M, opcode; outputs next AC, next carry, carry-write-enable.
- The FSM and registers stay in the top.

## Test plan
- Reset mid-EXEC of an ADD with AC=0x37, PC=5 → next edge: PC=0, AC=0x00, carry=0, `halted`=0, `mem_rd`=`mem_wr`=0, state IDLE.
- Program M0=0x49, M1=0x0A, M2=0xE0, M9=0x08, M10=0x02; pulse `start` → AC=0x0A, PC=3, `halted`=1 nine cycles after `start`.
- With `ACU_INDIRECT_EN`: M0=0x5C, M12=0x09, M9=0x08 → four cycles after FETCH begins, AC=0x08 and AR=9. Without the macro: same program gives AC=0x09 in 3 cycles.
- AC=0xFF, ADD of M=0x01 → AC=0x00, carry=1. Following BZ 7 → PC=7. Following SUB of M=0x01 → AC=0xFF, carry=1.
- AC=0x0A, STA 15 (0x6F) → exactly one cycle with `mem_wr`=1, `mem_addr`=15, `mem_wdata`=0x0A, `mem_rd`=0; M15 then reads 0x0A.
- BUN 15 with M15=0xF0 (NOP) → after the NOP executes at 15, PC=0 (wrap) and the next FETCH drives `mem_addr`=0.
